// File: rtl/vram_arb_rr.sv
// VRAM arbiter: vgen has absolute read priority, NCHAN r/w clients
// share the remaining slots round-robin or fixed; embedded single-port RAM.
module vram_arb_rr #(
  parameter int NCHAN     = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MASK_W    = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       vgen_sel_i,
  input  logic [ADDR_W-1:0]          vgen_addr_i,
  output logic                       vgen_valid_o,
  input  logic [NCHAN-1:0]           ch_sel_i,
  output logic [NCHAN-1:0]           ch_ack_o,
  input  logic [NCHAN-1:0]           ch_wr_i,
  input  logic [NCHAN*MASK_W-1:0]    ch_wr_mask_i,
  input  logic [NCHAN*ADDR_W-1:0]    ch_addr_i,
  input  logic [NCHAN*DATA_W-1:0]    ch_data_i,
  output logic [$clog2(NCHAN):0]     grant_idx_o,
  output logic [DATA_W-1:0]          vram_data_o
);

  localparam int GW    = $clog2(NCHAN) + 1;
  localparam int SW    = DATA_W / MASK_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [GW-1:0] NONE = '1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic [NCHAN-1:0] ack_q, ack_d;
  logic [NCHAN-1:0] elig;
  logic             vvalid_q, vvalid_d;
  logic [GW-1:0]    gidx_q, gidx_d;
  logic [GW-1:0]    rr_ptr_q, rr_ptr_d;

  logic             win_found;
  logic [GW-1:0]    win;
  logic [GW-1:0]    scan_start;

  logic              vram_wr;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic [MASK_W-1:0] vram_mask;
  logic [DATA_W-1:0] vram_bmask;

  // A channel acked this cycle sits out the next arbitration.
  always_comb begin
    elig = ch_sel_i & ~ack_q;
  end

  always_comb begin
    scan_start = (PRIO_MODE == 1) ? '0 : rr_ptr_q;
  end

  // Two passes: indices at/above the pointer, then wrap to the lowest.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (!win_found && elig[i] && (GW'(i) >= scan_start)) begin
        win_found = 1'b1;
        win       = GW'(i);
      end
    end
    for (int i = 0; i < NCHAN; i++) begin
      if (!win_found && elig[i]) begin
        win_found = 1'b1;
        win       = GW'(i);
      end
    end
  end

  always_comb begin
    ack_d      = '0;
    gidx_d     = NONE;
    rr_ptr_d   = rr_ptr_q;
    vvalid_d   = vgen_sel_i;
    vram_wr    = 1'b0;
    vram_addr  = ch_addr_i[ADDR_W-1:0];
    vram_wdata = ch_data_i[DATA_W-1:0];
    vram_mask  = '0;
    if (vgen_sel_i) begin
      vram_addr = vgen_addr_i;
    end else if (win_found) begin
      gidx_d = win;
      for (int i = 0; i < NCHAN; i++) begin
        if (win == GW'(i)) begin
          ack_d[i]   = 1'b1;
          vram_wr    = ch_wr_i[i] & ~reset_i;
          vram_addr  = ch_addr_i[i*ADDR_W +: ADDR_W];
          vram_wdata = ch_data_i[i*DATA_W +: DATA_W];
          vram_mask  = ch_wr_mask_i[i*MASK_W +: MASK_W];
        end
      end
      if (PRIO_MODE == 0 && NCHAN > 1) begin
        rr_ptr_d = (win == GW'(NCHAN-1)) ? '0 : win + GW'(1);
      end
    end
  end

  always_comb begin
    vram_bmask = '0;
    for (int m = 0; m < MASK_W; m++) begin
      vram_bmask[m*SW +: SW] = {SW{vram_mask[m]}};
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      ack_q    <= '0;
      vvalid_q <= 1'b0;
      gidx_q   <= NONE;
      rr_ptr_q <= '0;
    end else begin
      ack_q    <= ack_d;
      vvalid_q <= vvalid_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Array is never cleared; read data is read-first for a write slot.
  always_ff @(posedge clk) begin
    if (vram_wr) begin
      mem_q[vram_addr] <= (mem_q[vram_addr] & ~vram_bmask)
                        | (vram_wdata & vram_bmask);
    end
    rdata_q <= mem_q[vram_addr];
  end

  assign ch_ack_o     = ack_q;
  assign vgen_valid_o = vvalid_q;
  assign grant_idx_o  = gidx_q;
  assign vram_data_o  = rdata_q;

endmodule

// File: tb/tb_vram_arb_rr.sv
// Directed bench for vram_arb_rr: 2-ch round-robin, 3-ch round-robin
// and 2-ch fixed-priority instances.
module tb_vram_arb_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic        vgen_sel;
  logic [15:0] vgen_addr;

  // 2-channel round-robin
  logic [1:0]  sel, wr, ack;
  logic [7:0]  mask;
  logic [31:0] addr, data;
  logic [1:0]  gidx;
  logic        vvalid;
  logic [15:0] rdata;

  // 3-channel round-robin
  logic [2:0]  sel3, wr3, ack3, gidx3;
  logic [11:0] mask3;
  logic [47:0] addr3, data3;
  logic        vvalid3;
  logic [15:0] rdata3;

  // 2-channel fixed priority
  logic [1:0]  self, ackf, gidxf;
  logic        vvalidf;
  logic [15:0] rdataf;

  int total = 0;
  int bad   = 0;

  vram_arb_rr #(.NCHAN(2), .PRIO_MODE(0)) u_dut (
    .clk(clk), .reset_i(reset_i),
    .vgen_sel_i(vgen_sel), .vgen_addr_i(vgen_addr), .vgen_valid_o(vvalid),
    .ch_sel_i(sel), .ch_ack_o(ack), .ch_wr_i(wr), .ch_wr_mask_i(mask),
    .ch_addr_i(addr), .ch_data_i(data),
    .grant_idx_o(gidx), .vram_data_o(rdata)
  );

  vram_arb_rr #(.NCHAN(3), .PRIO_MODE(0)) u_d3 (
    .clk(clk), .reset_i(reset_i),
    .vgen_sel_i(vgen_sel), .vgen_addr_i(vgen_addr), .vgen_valid_o(vvalid3),
    .ch_sel_i(sel3), .ch_ack_o(ack3), .ch_wr_i(wr3), .ch_wr_mask_i(mask3),
    .ch_addr_i(addr3), .ch_data_i(data3),
    .grant_idx_o(gidx3), .vram_data_o(rdata3)
  );

  vram_arb_rr #(.NCHAN(2), .PRIO_MODE(1)) u_fx (
    .clk(clk), .reset_i(reset_i),
    .vgen_sel_i(vgen_sel), .vgen_addr_i(vgen_addr), .vgen_valid_o(vvalidf),
    .ch_sel_i(self), .ch_ack_o(ackf), .ch_wr_i(wr), .ch_wr_mask_i(mask),
    .ch_addr_i(addr), .ch_data_i(data),
    .grant_idx_o(gidxf), .vram_data_o(rdataf)
  );

  // Issues one access on u_dut and waits (bounded) for its ack.
  task automatic access(input int ch, input bit w, input logic [3:0] m,
                        input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic [1:0] gi,
                        output bit ok);
    @(negedge clk);
    sel[ch] = 1'b1;
    wr[ch]  = w;
    mask[ch*4 +: 4]  = m;
    addr[ch*16 +: 16] = a;
    data[ch*16 +: 16] = d;
    ok = 1'b0;
    rd = '0;
    gi = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack[ch]) begin
        rd = rdata;
        gi = gidx;
        ok = 1'b1;
        break;
      end
    end
    sel = '0;
    wr  = '0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ack !== 2'b00 || vvalid !== 1'b0 || gidx !== 2'b11) begin
      bad++;
      $display("FAIL reset2: ack=%b valid=%b gidx=%b want 00 0 11",
               ack, vvalid, gidx);
    end
    total++;
    if (ack3 !== 3'b000 || gidx3 !== 3'b111) begin
      bad++;
      $display("FAIL reset3: ack=%b gidx=%b want 000 111", ack3, gidx3);
    end
    total++;
    if (ackf !== 2'b00 || gidxf !== 2'b11) begin
      bad++;
      $display("FAIL resetf: ack=%b gidx=%b want 00 11", ackf, gidxf);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_vgen_priority();
    @(negedge clk);
    vgen_sel  = 1'b1;
    vgen_addr = 16'h0010;
    sel       = 2'b11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (vvalid !== 1'b1) begin
        bad++;
        $display("FAIL vgen_valid c%0d: got %b want 1", c, vvalid);
      end
      total++;
      if (ack !== 2'b00 || gidx !== 2'b11) begin
        bad++;
        $display("FAIL vgen_noack c%0d: ack=%b gidx=%b want 00 11",
                 c, ack, gidx);
      end
    end
    vgen_sel = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 2'b01 || gidx !== 2'b00 || vvalid !== 1'b0) begin
      bad++;
      $display("FAIL vgen_after0: ack=%b gidx=%b valid=%b want 01 00 0",
               ack, gidx, vvalid);
    end
    sel = 2'b10;
    @(negedge clk);
    total++;
    if (ack !== 2'b10 || gidx !== 2'b01) begin
      bad++;
      $display("FAIL vgen_after1: ack=%b gidx=%b want 10 01", ack, gidx);
    end
    sel = 2'b00;
    @(negedge clk);
    total++;
    if (ack !== 2'b00 || gidx !== 2'b11) begin
      bad++;
      $display("FAIL idle: ack=%b gidx=%b want 00 11", ack, gidx);
    end
  endtask

  task automatic test_rr3();
    logic [2:0] ea [4];
    logic [2:0] ei [4];
    ea = '{3'b001, 3'b010, 3'b100, 3'b001};
    ei = '{3'd0, 3'd1, 3'd2, 3'd0};
    @(negedge clk);
    sel3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (ack3 !== ea[c] || gidx3 !== ei[c]) begin
        bad++;
        $display("FAIL rr3 c%0d: ack=%b gidx=%0d want %b %0d",
                 c, ack3, gidx3, ea[c], ei[c]);
      end
    end
    sel3 = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_fixed();
    logic [1:0] ea [4];
    ea = '{2'b01, 2'b10, 2'b01, 2'b10};
    @(negedge clk);
    self = 2'b11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (ackf !== ea[c]) begin
        bad++;
        $display("FAIL fixed c%0d: ack=%b want %b", c, ackf, ea[c]);
      end
    end
    self = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_masked_write();
    logic [15:0] rd;
    logic [1:0]  gi;
    bit          ok;
    access(0, 1'b1, 4'b1111, 16'h0100, 16'h1234, rd, gi, ok);
    total++;
    if (!ok || gi !== 2'b00) begin
      bad++;
      $display("FAIL wr1_ack: ok=%0d gidx=%b want 1 00", ok, gi);
    end
    access(0, 1'b1, 4'b0011, 16'h0100, 16'hABCD, rd, gi, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wr2_ack: ok=%0d want 1", ok);
    end
    access(0, 1'b0, 4'b0000, 16'h0100, 16'h0000, rd, gi, ok);
    total++;
    if (!ok || rd !== 16'h12CD) begin
      bad++;
      $display("FAIL masked_rd: ok=%0d data=%h want 12cd", ok, rd);
    end
  endtask

  task automatic test_vgen_blocks_write();
    logic [15:0] rd;
    logic [1:0]  gi;
    bit          ok;
    access(1, 1'b1, 4'b1111, 16'h0200, 16'h1111, rd, gi, ok);
    total++;
    if (!ok || gi !== 2'b01) begin
      bad++;
      $display("FAIL pre_wr: ok=%0d gidx=%b want 1 01", ok, gi);
    end
    @(negedge clk);
    vgen_sel  = 1'b1;
    vgen_addr = 16'h0200;
    sel  = 2'b10;
    wr   = 2'b10;
    mask = 8'hF0;
    addr = {16'h0200, 16'h0000};
    data = {16'hBEEF, 16'h0000};
    @(negedge clk);
    total++;
    if (ack !== 2'b00 || vvalid !== 1'b1) begin
      bad++;
      $display("FAIL vblk1: ack=%b valid=%b want 00 1", ack, vvalid);
    end
    @(negedge clk);
    total++;
    if (ack !== 2'b00 || rdata !== 16'h1111) begin
      bad++;
      $display("FAIL vblk2: ack=%b data=%h want 00 1111", ack, rdata);
    end
    vgen_sel = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 2'b10 || vvalid !== 1'b0) begin
      bad++;
      $display("FAIL vblk3: ack=%b valid=%b want 10 0", ack, vvalid);
    end
    sel = 2'b00;
    wr  = 2'b00;
    access(0, 1'b0, 4'b0000, 16'h0200, 16'h0000, rd, gi, ok);
    total++;
    if (!ok || rd !== 16'hBEEF) begin
      bad++;
      $display("FAIL vblk_rd: ok=%0d data=%h want beef", ok, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    logic [1:0]  gi;
    bit          ok;
    access(0, 1'b1, 4'b1111, 16'h0300, 16'h7777, rd, gi, ok);
    @(negedge clk);
    sel  = 2'b01;
    wr   = 2'b01;
    mask = 8'h0F;
    addr = {16'h0000, 16'h0300};
    data = {16'h0000, 16'h9999};
    reset_i = 1'b1;
    @(negedge clk);
    total++;
    if (ack !== 2'b00 || gidx !== 2'b11) begin
      bad++;
      $display("FAIL rst_grant: ack=%b gidx=%b want 00 11", ack, gidx);
    end
    sel = 2'b00;
    wr  = 2'b00;
    reset_i = 1'b0;
    @(negedge clk);
    sel = 2'b01;
    @(negedge clk);
    total++;
    if (ack !== 2'b01 || rdata !== 16'h7777) begin
      bad++;
      $display("FAIL rst_word: ack=%b data=%h want 01 7777", ack, rdata);
    end
    reset_i = 1'b1;
    #1;
    total++;
    if (ack !== 2'b00 || gidx !== 2'b11) begin
      bad++;
      $display("FAIL rst_async: ack=%b gidx=%b want 00 11", ack, gidx);
    end
    sel = 2'b00;
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    sel = 2'b11;
    @(negedge clk);
    total++;
    if (ack !== 2'b01) begin
      bad++;
      $display("FAIL rst_ptr: ack=%b want 01", ack);
    end
    sel = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    reset_i   = 1'b1;
    vgen_sel  = 1'b0;
    vgen_addr = '0;
    sel  = '0;
    wr   = '0;
    mask = '0;
    addr = '0;
    data = '0;
    sel3  = '0;
    wr3   = '0;
    mask3 = '0;
    addr3 = '0;
    data3 = '0;
    self  = '0;
    test_reset();
    test_vgen_priority();
    test_rr3();
    test_fixed();
    test_masked_write();
    test_vgen_blocks_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
